// File: rtl/hazard_ctrl.sv
// Pipeline hazard and sequencing controller: load-use, redirects,
// data-memory waits and interrupt entry/exit for the 5-stage CPU.
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] id_rs1,
    input  logic [3:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [3:0] ex_reg_dst,
    input  logic       ex_mem_rd,
    input  logic       ex_reg_wr,
    input  logic       branch_taken,
    input  logic       returni_ex,
    input  logic       mem_req,
    input  logic       mem_ack,
    input  logic       irq,
    output logic       pc_stall,
    output logic       if_id_stall,
    output logic       if_id_flush,
    output logic       id_ex_stall,
    output logic       id_ex_flush,
    output logic       ex_mem_stall,
    output logic       int_inject,
    output logic       int_ack,
    output logic       mem_err
);

    typedef enum logic [1:0] {RUN, DRAIN, ENTER, ISR} state_t;

    localparam logic [7:0] DRAIN_INIT = 8'(DRAIN_CYCLES - 1);
    localparam logic [7:0] TIMEOUT    = 8'(MEM_TIMEOUT);
    localparam logic [7:0] TIMEOUT_M1 = 8'(MEM_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] drain_cnt, drain_nxt;
    logic [7:0] wait_cnt;
    logic       int_en, int_en_nxt;
    logic       mem_wait, load_use, redirect;
    logic       rs1_hit, rs2_hit;

    assign mem_wait = mem_req & ~mem_ack;
    assign rs1_hit  = id_uses_rs1 & (id_rs1 == ex_reg_dst);
    assign rs2_hit  = id_uses_rs2 & (id_rs2 == ex_reg_dst);
    assign load_use = ex_mem_rd & ex_reg_wr & (ex_reg_dst != 4'd0)
                    & (rs1_hit | rs2_hit);
    assign redirect = branch_taken | (returni_ex & (state == ISR));

    // Fires once, on the wait cycle whose increment reaches the limit.
    assign mem_err = mem_wait & (wait_cnt == TIMEOUT_M1);

    always_comb begin
        state_nxt    = state;
        drain_nxt    = drain_cnt;
        int_en_nxt   = int_en;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        int_inject   = 1'b0;
        int_ack      = 1'b0;
        if (mem_wait) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
        end else if (redirect | returni_ex) begin
            // A returni outside ISR is still a plain redirect.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            if (returni_ex) begin
                int_en_nxt = 1'b1;
                if (state == ISR) state_nxt = RUN;
            end
        end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    if (irq & int_en) begin
                        state_nxt = DRAIN;
                        drain_nxt = DRAIN_INIT;
                    end
                end
                DRAIN: begin
                    pc_stall    = 1'b1;
                    if_id_flush = 1'b1;
                    if (drain_cnt == 8'd0) state_nxt = ENTER;
                    else drain_nxt = drain_cnt - 8'd1;
                end
                ENTER: begin
                    pc_stall    = 1'b1;
                    if_id_flush = 1'b1;
                    int_inject  = 1'b1;
                    int_ack     = 1'b1;
                    int_en_nxt  = 1'b0;
                    state_nxt   = ISR;
                end
                ISR: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= 8'd0;
            int_en    <= 1'b1;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            int_en    <= int_en_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !mem_wait) wait_cnt <= 8'd0;
        else if (wait_cnt != TIMEOUT) wait_cnt <= wait_cnt + 8'd1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with DRAIN_CYCLES=2, MEM_TIMEOUT=4.
module tb_hazard_ctrl;

    localparam logic [8:0] PC  = 9'h100;
    localparam logic [8:0] IFS = 9'h080;
    localparam logic [8:0] IFF = 9'h040;
    localparam logic [8:0] IDS = 9'h020;
    localparam logic [8:0] IDF = 9'h010;
    localparam logic [8:0] EXS = 9'h008;
    localparam logic [8:0] INJ = 9'h004;
    localparam logic [8:0] ACK = 9'h002;
    localparam logic [8:0] ERR = 9'h001;
    localparam logic [8:0] ALLST = PC | IFS | IDS | EXS;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] id_rs1, id_rs2, ex_reg_dst;
    logic id_uses_rs1, id_uses_rs2, ex_mem_rd, ex_reg_wr;
    logic branch_taken, returni_ex, mem_req, mem_ack, irq;
    logic pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic ex_mem_stall, int_inject, int_ack, mem_err;
    logic [8:0] outs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.DRAIN_CYCLES(2), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_reg_dst(ex_reg_dst), .ex_mem_rd(ex_mem_rd), .ex_reg_wr(ex_reg_wr),
        .branch_taken(branch_taken), .returni_ex(returni_ex),
        .mem_req(mem_req), .mem_ack(mem_ack), .irq(irq),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall),
        .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
        .int_inject(int_inject), .int_ack(int_ack), .mem_err(mem_err)
    );

    assign outs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                   id_ex_flush, ex_mem_stall, int_inject, int_ack, mem_err};

    task automatic check(input string tag, input logic [8:0] got,
                         input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Inputs are set at posedge+1; outputs checked mid-cycle, then advance.
    task automatic cyc(input string tag, input logic [8:0] exp);
        #3;
        check(tag, outs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        id_rs1 = '0; id_rs2 = '0; ex_reg_dst = '0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_mem_rd = 0; ex_reg_wr = 0;
        branch_taken = 0; returni_ex = 0; mem_req = 0; mem_ack = 0; irq = 0;
        tick();
        tick();
        rst = 1'b0;
        cyc("reset", 9'h000);

        // load-use on rs2
        ex_mem_rd = 1; ex_reg_wr = 1; ex_reg_dst = 4'd5;
        id_rs2 = 4'd5; id_uses_rs2 = 1;
        cyc("lu_hit", PC | IFS | IDF);
        ex_mem_rd = 0; ex_reg_wr = 0;
        cyc("lu_after", 9'h000);
        ex_mem_rd = 1; ex_reg_wr = 1; ex_reg_dst = 4'd0; id_rs2 = 4'd0;
        cyc("lu_r0", 9'h000);
        ex_reg_dst = 4'd7; id_rs1 = 4'd7; id_uses_rs2 = 0; id_uses_rs1 = 0;
        cyc("lu_unused", 9'h000);
        id_uses_rs1 = 1;
        cyc("lu_rs1", PC | IFS | IDF);

        // load-use together with branch: redirect wins
        branch_taken = 1;
        cyc("lu_br", IFF | IDF);
        ex_mem_rd = 0; ex_reg_wr = 0; id_uses_rs1 = 0; branch_taken = 0;

        // branch deferred by memory wait
        mem_req = 1; branch_taken = 1;
        for (int i = 0; i < 3; i++) cyc("br_wait", ALLST);
        mem_ack = 1;
        cyc("br_ack", IFF | IDF);
        mem_req = 0; mem_ack = 0; branch_taken = 0;
        cyc("br_done", 9'h000);

        // interrupt entry
        irq = 1;
        cyc("irq_dec", 9'h000);
        cyc("drain1", PC | IFF);
        cyc("drain2", PC | IFF);
        cyc("enter", PC | IFF | INJ | ACK);
        cyc("isr_irq1", 9'h000);
        cyc("isr_irq2", 9'h000);
        irq = 0; returni_ex = 1;
        cyc("returni", IFF | IDF);
        returni_ex = 0; irq = 1;
        cyc("irq2_dec", 9'h000);
        cyc("irq2_dr1", PC | IFF);
        // irq drops and a branch lands mid-drain; entry still completes
        irq = 0; branch_taken = 1;
        cyc("drain_br", IFF | IDF);
        branch_taken = 0;
        cyc("irq2_dr2", PC | IFF);
        cyc("irq2_ent", PC | IFF | INJ | ACK);
        cyc("irq2_isr", 9'h000);
        returni_ex = 1;
        cyc("returni2", IFF | IDF);
        returni_ex = 0;

        // memory timeout at 4 wait cycles
        mem_req = 1;
        for (int i = 1; i <= 6; i++)
            cyc("to_wait", (i == 4) ? (ALLST | ERR) : ALLST);
        mem_ack = 1;
        cyc("to_ack", 9'h000);
        mem_ack = 0;
        for (int i = 1; i <= 4; i++)
            cyc("to_rewait", (i == 4) ? (ALLST | ERR) : ALLST);
        mem_req = 0;
        cyc("to_idle", 9'h000);

        // reset in the second DRAIN cycle, irq held
        irq = 1;
        cyc("rd_dec", 9'h000);
        cyc("rd_dr1", PC | IFF);
        rst = 1;
        tick();
        rst = 0;
        cyc("rd_after", 9'h000);
        cyc("rd_dr1b", PC | IFF);
        cyc("rd_dr2b", PC | IFF);
        cyc("rd_enter", PC | IFF | INJ | ACK);
        irq = 0;
        cyc("rd_isr", 9'h000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
